// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table sequencer: walks every N_IN-bit vector, holds it HOLD cycles,
// then compares the gate-under-test output against a NOR/NAND/OR/AND reference.
module gate_truth_checker #(
   parameter int N_IN = 2,
   parameter int HOLD = 2,
   parameter int MODE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            dut_out,
   output logic [N_IN-1:0] vec,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_seen,
   output logic [N_IN-1:0] first_fail_vec
);

   localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);
   localparam logic [N_IN-1:0] VEC_LAST = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            sample;
   logic            miss;
   logic [N_IN:0]   err_nxt;

   function automatic logic ref_out(input logic [N_IN-1:0] v);
      case (MODE)
         0:       ref_out = ~|v;
         1:       ref_out = ~&v;
         2:       ref_out = |v;
         default: ref_out = &v;
      endcase
   endfunction

   // Case-inequality so that an X or Z from the gate model is always a failure.
   always_comb begin
      sample  = (state == SETTLE) && !abort && (cnt == CNT_LAST);
      miss    = sample && (dut_out !== ref_out(vec));
      err_nxt = err_count + {{N_IN{1'b0}}, miss};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         cnt            <= '0;
         vec            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         fail_seen      <= 1'b0;
         first_fail_vec <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= SETTLE;
                  cnt            <= '0;
                  vec            <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  fail_seen      <= 1'b0;
                  first_fail_vec <= '0;
               end
            end
            SETTLE: begin
               if (abort) begin
                  // Partial error results are kept for inspection after an abort.
                  state <= IDLE;
                  busy  <= 1'b0;
                  vec   <= '0;
                  cnt   <= '0;
               end else if (sample) begin
                  err_count <= err_nxt;
                  if (miss && !fail_seen) begin
                     first_fail_vec <= vec;
                     fail_seen      <= 1'b1;
                  end
                  if (vec == VEC_LAST) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_nxt == '0);
                  end else begin
                     vec <= vec + 1'b1;
                     cnt <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Parametrised, self-checking exhaustive truth-table sequencer for switch-level gate models. It drives every input combination of an N-input gate under test, holds each vector for a programmable settle time, and compares the gate output against a selectable reference function (NOR, NAND, OR, AND). It counts mismatches and flags the first failing vector. It sits beside any CMOSxxx switch-level model, replacing hand-written per-gate stimulus sequences with one reusable, synthesisable checker.

## Interface

Parameters:
- N_IN, 2: gate input count; legal range 1..8.
- HOLD, 2: clock cycles each vector is driven before the output is sampled; legal range ≥1.
- MODE, 0: reference function. 0 = NOR, 1 = NAND, 2 = OR, 3 = AND.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begins a run when sampled high in IDLE or DONE.
- abort  in  1  ends a run without completing it.
- dut_out  in  1  output of the gate under test.
- vec  out  N_IN  input vector driven to the gate; bit i drives gate input i+1.
- busy  out  1  high while a run is in progress.
- done  out  1  high after a run completes; held until the next start or reset.
- pass  out  1  done && (err_count == 0).
- err_count  out  N_IN+1  number of mismatching vectors; cannot overflow.
- fail_seen  out  1  at least one mismatch in this run.
- first_fail_vec  out  N_IN  vector value at the first mismatch.

## Operation

- States: IDLE, SETTLE, DONE. All outputs are registered.
- Reset (rst low at an edge):
  - State goes to IDLE.
  - vec = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_seen = 0, first_fail_vec = 0.
  - The hold counter is cleared.
  - Reset overrides every other input, including mid-run.
- IDLE or DONE with start = 1:
  - vec <= 0, counter <= 0.
  - err_count, fail_seen, first_fail_vec and done are cleared.
  - busy <= 1, state goes to SETTLE.
- SETTLE:
  - The counter increments every cycle.
  - On the edge where counter == HOLD-1, dut_out is sampled and compared to ref(vec).
  - ref(vec):
    - NOR: ~|vec
    - NAND: ~&vec
    - OR: |vec
    - AND: &vec
  - Mismatch uses case-inequality. A dut_out of X or Z counts as a mismatch.
  - On a mismatch: err_count increments. If fail_seen = 0, first_fail_vec <= vec and fail_seen <= 1.
  - If vec is not all-ones: vec <= vec+1 and counter <= 0.
  - If vec is all-ones: state goes to DONE, busy <= 0, done <= 1. vec keeps the all-ones value.
- abort = 1 in SETTLE:
  - State goes to IDLE, busy <= 0, done stays 0, vec <= 0.
  - err_count, fail_seen and first_fail_vec hold their partial values.
  - abort has no effect in IDLE and DONE.
- start while in SETTLE is ignored.
- If abort and start are both high in SETTLE, abort wins.
- The reference function is not evaluated outside sample edges.

## Timing

- Start edge = cycle 0.
- Vector k is driven from cycle k·HOLD+1 and sampled at the edge ending cycle (k+1)·HOLD.
- done rises at cycle 2^N_IN · HOLD after the start edge.
  - N_IN=2, HOLD=2: 8 cycles.
  - N_IN=3, HOLD=2: 16 cycles.
- err_count, first_fail_vec and fail_seen update on the same edge as the failing sample.
- pass is valid in the same cycle as done.
- HOLD=1: the vector changes every cycle with zero settle margin. This is legal for zero-delay models only.
- Restart from DONE: the edge after start, vec = 0 and the result outputs are cleared.

## Test plan

- Ideal NOR model, N_IN=2, HOLD=2, MODE=0: pulse start.
  - Required: vec walks 0,1,2,3 at 2-cycle spacing.
  - done = 1 at cycle 8, pass = 1, err_count = 0.
- Stuck-at-1 model (dut_out = 1), MODE=0, N_IN=2:
  - Required: err_count = 3, fail_seen = 1, first_fail_vec = 1, pass = 0.
- Output tied to Z, N_IN=2:
  - Required: err_count = 4, first_fail_vec = 0.
- Ideal NAND model, N_IN=3, MODE=1, HOLD=3:
  - Required: done at cycle 24, err_count = 0.
  - A start pulse at cycle 5 is ignored: vec sequence unchanged.
- Abort and reset:
  - Stuck-at-1 model, abort at cycle 5. Required: IDLE, busy = 0, done = 0, vec = 0, err_count = 1 retained.
  - Then restart and drop rst low at cycle 3. Required: all outputs zero at the next edge, and the following start runs cleanly.
- Back-to-back runs:
  - start held high through DONE. Required: the run re-launches on the edge after done, results cleared, second run identical to the first.
